// File: rtl/seg_counter_scan.sv
// seg_counter_scan: prescaled hex/BCD counter shown on a multiplexed common-anode
// seven-segment bank with inter-digit blanking, leading-zero suppression and a display hold latch.
module seg_counter_scan #(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLANK    = 2,
  parameter int unsigned DECIMAL  = 0,
  parameter int unsigned LZ_BLANK = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                CLR,
  input  logic                HOLD,
  output logic [6:0]          SEG,
  output logic [DIGITS-1:0]   COMM,
  output logic [4*DIGITS-1:0] COUNT,
  output logic                TICK,
  output logic                WRAP
);

  localparam int unsigned P  = CLK_HZ / TICK_HZ;
  localparam int unsigned S  = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned SW = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] NIB_MAX = (DECIMAL != 0) ? 4'd9 : 4'd15;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low glyphs {g..a} for nibble values 0-F.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'h40;
      4'h1:    font = 7'h79;
      4'h2:    font = 7'h24;
      4'h3:    font = 7'h30;
      4'h4:    font = 7'h19;
      4'h5:    font = 7'h12;
      4'h6:    font = 7'h02;
      4'h7:    font = 7'h78;
      4'h8:    font = 7'h00;
      4'h9:    font = 7'h10;
      4'hA:    font = 7'h08;
      4'hB:    font = 7'h03;
      4'hC:    font = 7'h46;
      4'hD:    font = 7'h21;
      4'hE:    font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     disp_q, disp_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] comm_q, comm_d;
  logic [6:0]        seg_q, seg_d;

  logic [CW-1:0]     inc_c;
  logic              carry_c;
  logic [3:0]        nib_c;
  logic              zero_above_c;
  logic [DIGITS-1:0] lz_dark_c;
  logic [3:0]        sel_nib_c;
  logic              sel_dark_c;

  // Nibble-wise ripple increment; carry out of the top nibble means the count rolled to zero.
  always_comb begin
    inc_c   = count_q;
    carry_c = 1'b1;
    nib_c   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_c = count_q[4*i +: 4];
      if (carry_c) begin
        if (nib_c >= NIB_MAX) begin
          nib_c = 4'd0;
        end else begin
          nib_c   = nib_c + 4'd1;
          carry_c = 1'b0;
        end
      end
      inc_c[4*i +: 4] = nib_c;
    end
  end

  // Leading-zero mask and selection of the latched nibble for the current scan index.
  always_comb begin
    zero_above_c = 1'b1;
    lz_dark_c    = '0;
    sel_nib_c    = 4'd0;
    sel_dark_c   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_c = zero_above_c & (disp_q[4*i +: 4] == 4'd0);
      lz_dark_c[i] = (LZ_BLANK != 0) && (i > 0) && zero_above_c;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib_c  = disp_q[4*i +: 4];
        sel_dark_c = lz_dark_c[i];
      end
    end
  end

  // Prescaler, counter and display latch; CLR overrides tick/enable and clears the latch.
  always_comb begin
    presc_d = (presc_q == '0) ? PW'(P - 1) : presc_q - PW'(1);
    tick_d  = (presc_d == '0);
    count_d = count_q;
    wrap_d  = 1'b0;
    if (tick_q && EN) begin
      count_d = inc_c;
      wrap_d  = carry_c;
    end
    disp_d = HOLD ? disp_q : count_q;
    if (CLR) begin
      presc_d = PW'(P - 1);
      tick_d  = 1'b0;
      count_d = '0;
      wrap_d  = 1'b0;
      disp_d  = '0;
    end
  end

  // Scan slot/index sequencing and the segment/anode drive for the next cycle.
  always_comb begin
    slot_d = slot_q + SW'(1);
    idx_d  = idx_q;
    if (slot_q == SW'(S - 1)) begin
      slot_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    comm_d = '0;
    seg_d  = SEG_OFF;
    if (slot_q >= SW'(BLANK)) begin
      for (int i = 0; i < DIGITS; i++) begin
        comm_d[i] = (idx_q == IW'(i));
      end
      if (!sel_dark_c && !((DECIMAL != 0) && (sel_nib_c > 4'd9))) begin
        seg_d = font(sel_nib_c);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= PW'(P - 1);
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      count_q <= '0;
      disp_q  <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      comm_q  <= '0;
      seg_q   <= SEG_OFF;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      count_q <= count_d;
      disp_q  <= disp_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      comm_q  <= comm_d;
      seg_q   <= seg_d;
    end
  end

  assign SEG   = seg_q;
  assign COMM  = comm_q;
  assign COUNT = count_q;
  assign TICK  = tick_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_seg_counter_scan.sv
// tb_seg_counter_scan: directed checks of prescaler, hex/BCD counting, wrap, enable,
// clear, hold latch, scan timing, leading-zero blanking and mid-slot reset.
module tb_seg_counter_scan;

  logic clk = 1'b0;
  logic rst, en, clr, hold;
  logic rst_f, en_f;

  logic [6:0]  a_seg;  logic [3:0] a_comm; logic [15:0] a_count; logic a_tick, a_wrap;
  logic [6:0]  b_seg;  logic [1:0] b_comm; logic [7:0]  b_count; logic b_tick, b_wrap;
  logic [6:0]  c_seg;  logic [1:0] c_comm; logic [7:0]  c_count; logic c_tick, c_wrap;
  logic [6:0]  e_seg;  logic [3:0] e_comm; logic [15:0] e_count; logic e_tick, e_wrap;

  always #5 clk = ~clk;

  // Main unit: P=10, S=8, 4 hex digits.
  seg_counter_scan #(.CLK_HZ(320), .TICK_HZ(32), .DIGITS(4), .SCAN_HZ(10), .BLANK(2),
                     .DECIMAL(0), .LZ_BLANK(0)) u_a (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .HOLD(hold),
    .SEG(a_seg), .COMM(a_comm), .COUNT(a_count), .TICK(a_tick), .WRAP(a_wrap));

  // Fast units (P=2) sharing controls: 2-digit hex, 2-digit BCD, 4-digit hex with LZ blanking.
  seg_counter_scan #(.CLK_HZ(320), .TICK_HZ(160), .DIGITS(2), .SCAN_HZ(20), .BLANK(2),
                     .DECIMAL(0), .LZ_BLANK(0)) u_b (
    .CLK(clk), .RST(rst_f), .EN(en_f), .CLR(1'b0), .HOLD(1'b0),
    .SEG(b_seg), .COMM(b_comm), .COUNT(b_count), .TICK(b_tick), .WRAP(b_wrap));

  seg_counter_scan #(.CLK_HZ(320), .TICK_HZ(160), .DIGITS(2), .SCAN_HZ(20), .BLANK(2),
                     .DECIMAL(1), .LZ_BLANK(0)) u_c (
    .CLK(clk), .RST(rst_f), .EN(en_f), .CLR(1'b0), .HOLD(1'b0),
    .SEG(c_seg), .COMM(c_comm), .COUNT(c_count), .TICK(c_tick), .WRAP(c_wrap));

  seg_counter_scan #(.CLK_HZ(320), .TICK_HZ(160), .DIGITS(4), .SCAN_HZ(10), .BLANK(2),
                     .DECIMAL(0), .LZ_BLANK(1)) u_e (
    .CLK(clk), .RST(rst_f), .EN(en_f), .CLR(1'b0), .HOLD(1'b0),
    .SEG(e_seg), .COMM(e_comm), .COUNT(e_count), .TICK(e_tick), .WRAP(e_wrap));

  logic [6:0] font_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_chk = 0;
  int n_err = 0;
  int nt    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_wait_tick();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!a_tick && budget < 40);
    if (!a_tick) chk("a_tick_timeout", 32'(a_tick), 32'd1);
  endtask

  task automatic a_digit0(input string tag, input logic [6:0] exp);
    int budget;
    budget = 0;
    while (a_comm != 4'b0001 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_comm"}, 32'(a_comm), 32'h1);
    chk({tag, "_seg"}, 32'(a_seg), 32'(exp));
  endtask

  // Advance the fast units to a total of 'target' accepted ticks, then one more cycle.
  task automatic ftick_to(input int target, input bit stop);
    int budget;
    budget = 0;
    while (nt < target && budget < 20000) begin
      @(negedge clk);
      budget++;
      if (b_tick && en_f) nt++;
    end
    chk("ftick_reached", 32'(nt), 32'(target));
    @(negedge clk);
    if (stop) en_f = 1'b0;
  endtask

  task automatic fstep();
    @(negedge clk);
    if (b_tick && en_f) nt++;
  endtask

  task automatic fresume();
    @(negedge clk);
    if (b_tick) @(negedge clk);
    en_f = 1'b1;
  endtask

  task automatic e_digits(input string tag, input logic [6:0] x3, input logic [6:0] x2,
                          input logic [6:0] x1, input logic [6:0] x0);
    logic [6:0] ex [4];
    logic [3:0] seen;
    int multi;
    ex[0] = x0; ex[1] = x1; ex[2] = x2; ex[3] = x3;
    seen  = '0;
    multi = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ($countones(e_comm) > 1) multi++;
      for (int d = 0; d < 4; d++) begin
        if (e_comm == 4'(1 << d) && !seen[d]) begin
          seen[d] = 1'b1;
          chk($sformatf("%s_d%0d", tag, d), 32'(e_seg), 32'(ex[d]));
        end
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'hF);
    chk({tag, "_onehot"}, 32'(multi), 32'd0);
  endtask

  initial begin
    int c, s, d, cyc;
    logic [3:0] ecomm;
    logic [6:0] eseg;

    rst = 1'b1; en = 1'b1; clr = 1'b0; hold = 1'b0;
    rst_f = 1'b1; en_f = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(a_count), 32'h0);
    chk("rst_comm",  32'(a_comm),  32'h0);
    chk("rst_seg",   32'(a_seg),   32'h7F);
    chk("rst_tick",  32'(a_tick),  32'h0);
    chk("rst_wrap",  32'(a_wrap),  32'h0);
    rst = 1'b0;

    // Cycle c after reset: tick every 10th, scan 2 blank + 6 lit per 8-cycle slot.
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      c = k + 1;
      s = (c - 2) % 8;
      d = ((c - 2) / 8) % 4;
      ecomm = (s < 2) ? 4'b0000 : 4'(1 << d);
      eseg  = (s < 2) ? 7'h7F : ((d == 0) ? font_t[(c - 3) / 10] : 7'h40);
      chk($sformatf("tick_c%0d", c),  32'(a_tick),  32'(c % 10 == 0));
      chk($sformatf("count_c%0d", c), 32'(a_count), 32'((c - 1) / 10));
      chk($sformatf("comm_c%0d", c),  32'(a_comm),  32'(ecomm));
      chk($sformatf("seg_c%0d", c),   32'(a_seg),   32'(eseg));
    end

    // Enable low discards three ticks, TICK keeps pulsing.
    en = 1'b0;
    repeat (3) begin
      a_wait_tick();
      chk("en_low_count", 32'(a_count), 32'h4);
    end
    @(negedge clk);
    chk("en_low_after", 32'(a_count), 32'h4);
    en = 1'b1;
    a_wait_tick();
    @(negedge clk);
    chk("en_resume", 32'(a_count), 32'h5);

    // Hold freezes the display at 5 while the count moves to 9.
    @(negedge clk);
    hold = 1'b1;
    repeat (4) a_wait_tick();
    @(negedge clk);
    chk("hold_count", 32'(a_count), 32'h9);
    en = 1'b0;
    a_digit0("hold_d0", 7'h12);
    hold = 1'b0;
    repeat (3) @(negedge clk);
    a_digit0("release_d0", 7'h10);

    // Clear coinciding with a tick; hold active so the latch clear is observable.
    en = 1'b1;
    a_wait_tick();
    clr = 1'b1;
    hold = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_count", 32'(a_count), 32'h0);
    chk("clr_wrap",  32'(a_wrap),  32'h0);
    chk("clr_tick",  32'(a_tick),  32'h0);
    cyc = 1;
    while (!a_tick && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("clr_next_tick", 32'(cyc), 32'd10);
    @(negedge clk);
    chk("clr_count1", 32'(a_count), 32'h1);
    a_digit0("clr_hold_d0", 7'h40);
    hold = 1'b0;

    // Fast units: BCD carry/wrap, hex wrap, leading-zero display, mid-slot reset.
    rst_f = 1'b0;
    nt = 0;
    ftick_to(19, 1'b0);
    chk("bcd_19", 32'(c_count), 32'h19);
    chk("hex_13", 32'(b_count), 32'h13);
    ftick_to(20, 1'b0);
    chk("bcd_20", 32'(c_count), 32'h20);
    ftick_to(99, 1'b0);
    chk("bcd_99", 32'(c_count), 32'h99);
    chk("bcd_99_wrap", 32'(c_wrap), 32'h0);
    ftick_to(100, 1'b0);
    chk("bcd_00", 32'(c_count), 32'h00);
    chk("bcd_wrap", 32'(c_wrap), 32'h1);
    chk("hex_64", 32'(b_count), 32'h64);
    chk("hex_64_wrap", 32'(b_wrap), 32'h0);
    fstep();
    chk("bcd_wrap_1cyc", 32'(c_wrap), 32'h0);

    ftick_to(160, 1'b1);
    chk("lz_count", 32'(e_count), 32'h00A0);
    chk("bcd_60", 32'(c_count), 32'h60);
    e_digits("lz_a0", 7'h7F, 7'h7F, 7'h08, 7'h40);
    fresume();

    ftick_to(255, 1'b0);
    chk("hex_ff", 32'(b_count), 32'hFF);
    chk("hex_ff_wrap", 32'(b_wrap), 32'h0);
    ftick_to(256, 1'b0);
    chk("hex_00", 32'(b_count), 32'h00);
    chk("hex_wrap", 32'(b_wrap), 32'h1);
    chk("bcd_56", 32'(c_count), 32'h56);
    fstep();
    chk("hex_wrap_1cyc", 32'(b_wrap), 32'h0);

    ftick_to(4660, 1'b1);
    chk("e_1234", 32'(e_count), 32'h1234);
    e_digits("e1234", 7'h79, 7'h24, 7'h30, 7'h19);

    cyc = 0;
    while (e_comm == 4'd0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_slot", 32'($countones(e_comm)), 32'd1);
    rst_f = 1'b1;
    @(negedge clk);
    chk("mrst_count", 32'(e_count), 32'h0);
    chk("mrst_comm",  32'(e_comm),  32'h0);
    chk("mrst_seg",   32'(e_seg),   32'h7F);
    chk("mrst_tick",  32'(e_tick),  32'h0);
    rst_f = 1'b0;
    @(negedge clk);
    chk("mrst_blank0", 32'(e_comm), 32'h0);
    @(negedge clk);
    chk("mrst_blank1", 32'(e_comm), 32'h0);
    chk("mrst_blank1_seg", 32'(e_seg), 32'h7F);
    @(negedge clk);
    chk("mrst_d0_comm", 32'(e_comm), 32'h1);
    chk("mrst_d0_seg",  32'(e_seg),  32'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
